// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encoding and default datapath width for the
//                registered ALU (alu_core / alu_synth_wrapper).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the ALU datapath.
    localparam int DEFAULT_WIDTH = 4;

    // Opcode width; all 2^3 encodings are assigned, so no illegal opcode exists.
    localparam int OP_W = 3;

    // Opcode encoding.
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHR = 3'b110;
    localparam logic [OP_W-1:0] OP_SHL = 3'b111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU. Selects one of eight operations on
//                a/b and produces the WIDTH-bit result plus a carry, borrow or
//                shift-out flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] res,
    output logic             cy
);

    // One extra bit on the arithmetic path holds the carry (ADD) or the
    // borrow (SUB); for unsigned subtraction the top bit is 1 exactly when a < b.
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Shifts are done on a WIDTH+1 vector with a guard bit on the side the
    // data leaves. The guard bit then holds the last bit shifted out for
    // 1 <= b <= WIDTH. It is naturally 0 for b == 0 (nothing left) and for
    // b > WIDTH (the last bit out was a shifted-in zero), so no range
    // compare on b is needed.
    logic [WIDTH:0] w_shr_ext;
    logic [WIDTH:0] w_shl_ext;

    // Adder/subtractor and guarded shifters, computed for every opcode.
    always_comb begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_shr_ext = {a, 1'b0} >> b;
        w_shl_ext = {1'b0, a} << b;
    end

    // Operation select.
    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (op)
            OP_ADD: begin
                res = w_sum[WIDTH-1:0];
                cy  = w_sum[WIDTH];
            end
            OP_SUB: begin
                res = w_diff[WIDTH-1:0];
                cy  = w_diff[WIDTH];
            end
            OP_AND: res = a & b;
            OP_XOR: res = a ^ b;
            OP_OR:  res = a | b;
            OP_NOT: res = ~a;
            OP_SHR: begin
                res = w_shr_ext[WIDTH:1];
                cy  = w_shr_ext[0];
            end
            OP_SHL: begin
                res = w_shl_ext[WIDTH-1:0];
                cy  = w_shl_ext[WIDTH];
            end
            default: begin
                res = '0;
                cy  = 1'b0;
            end
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_synth_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : alu_synth_wrapper
//  Description : Synthesis top for the ALU datapath. Registers the output of
//                alu_core, giving one-cycle latency at one operation per clock.
//                rst_n is a synchronous, ACTIVE-HIGH reset despite its name.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_synth_wrapper
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a   (a),
        .b   (b),
        .op  (op),
        .res (w_res),
        .cy  (w_cy)
    );

    // Output register; reset (active when rst_n is 1) wins over the new value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_res;
            r_carry  <= w_cy;
        end
    end

    assign result = r_result;
    assign carry  = r_carry;

endmodule : alu_synth_wrapper
`default_nettype wire

// File: tb/tb_alu_synth_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_synth_wrapper
//  Description : Self-checking bench for alu_synth_wrapper (WIDTH = 4).
//                Behavioural reference model plus literal directed vectors,
//                followed by randomized traffic with mid-stream resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_synth_wrapper;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         carry;

    int tests_run = 0;
    int tests_failed = 0;

    alu_synth_wrapper #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .carry  (carry)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model from the operation table, using integer arithmetic.
    // Returns {carry, result}.
    function automatic logic [W:0] model(input int av, input int bv, input int o);
        int r;
        int c;
        int m;
        m = 2 ** W;
        r = 0;
        c = 0;
        case (o)
            0: begin r = (av + bv) % m;     c = ((av + bv) >= m) ? 1 : 0; end
            1: begin r = (av - bv + m) % m; c = (av < bv) ? 1 : 0;        end
            2: r = av & bv;
            3: r = av ^ bv;
            4: r = av | bv;
            5: r = (m - 1) - av;
            6: begin
                r = av / (2 ** bv);
                c = (bv >= 1 && bv <= W) ? (av / (2 ** (bv - 1))) % 2 : 0;
            end
            default: begin
                r = (av * (2 ** bv)) % m;
                c = (bv >= 1 && bv <= W) ? (av / (2 ** (W - bv))) % 2 : 0;
            end
        endcase
        return {c[0], r[W-1:0]};
    endfunction

    // Expected outputs one edge after the sampled inputs.
    logic [W-1:0] exp_result;
    logic         exp_carry;
    logic         exp_valid = 1'b0;

    always @(posedge clk) begin
        logic [W:0] m;
        m = model(int'(a), int'(b), int'(op));
        exp_valid  <= 1'b1;
        exp_result <= rst_n ? '0 : m[W-1:0];
        exp_carry  <= rst_n ? 1'b0 : m[W];
    end

    // Continuous compare of DUT against the model, just after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_valid) begin
            tests_run++;
            if (result !== exp_result || carry !== exp_carry) begin
                tests_failed++;
                $display("FAIL model_cmp t=%0t: got result=%b carry=%b, expected result=%b carry=%b",
                         $time, result, carry, exp_result, exp_carry);
            end
        end
    end

    // Literal check of the DUT outputs and of the model for the same vector.
    task automatic check_lit(input string name, input logic [W-1:0] er, input logic ec,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [2:0] ov, input logic in_reset);
        logic [W:0] m;
        tests_run++;
        if (result !== er || carry !== ec) begin
            tests_failed++;
            $display("FAIL %s: got result=%b carry=%b, expected result=%b carry=%b",
                     name, result, carry, er, ec);
        end
        if (!in_reset) begin
            m = model(int'(av), int'(bv), int'(ov));
            tests_run++;
            if (m !== {ec, er}) begin
                tests_failed++;
                $display("FAIL %s_model: got %b, expected %b", name, m, {ec, er});
            end
        end
    endtask

    // Apply one vector, clock it, then check against literal expectations.
    task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [2:0] ov, input logic [W-1:0] er, input logic ec);
        @(negedge clk);
        a = av; b = bv; op = ov;
        @(posedge clk);
        #2;
        check_lit(name, er, ec, av, bv, ov, 1'b0);
    endtask

    initial begin
        // Reset held for three edges with non-zero inputs.
        rst_n = 1'b1;
        a = 4'b1111; b = 4'b0000; op = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check_lit("reset_hold", 4'b0000, 1'b0, a, b, op, 1'b1);
        end
        // First edge after release takes the inputs sampled at that edge.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check_lit("reset_release", 4'b1111, 1'b0, 4'b1111, 4'b0000, 3'b111, 1'b0);

        directed("add_ovf",   4'b1111, 4'b0110, 3'b000, 4'b0101, 1'b1);
        directed("sub_eq",    4'b1010, 4'b1010, 3'b001, 4'b0000, 1'b0);
        directed("sub_brw",   4'b0010, 4'b0110, 3'b001, 4'b1100, 1'b1);
        directed("shl_1",     4'b1111, 4'b0001, 3'b111, 4'b1110, 1'b1);
        directed("shl_4",     4'b1111, 4'b0100, 3'b111, 4'b0000, 1'b1);
        directed("shl_5",     4'b1111, 4'b0101, 3'b111, 4'b0000, 1'b0);
        directed("shr_1",     4'b1111, 4'b0001, 3'b110, 4'b0111, 1'b1);
        directed("shr_5",     4'b1111, 4'b0101, 3'b110, 4'b0000, 1'b0);
        directed("shr_4",     4'b1000, 4'b0100, 3'b110, 4'b0000, 1'b1);
        directed("shr_0",     4'b1011, 4'b0000, 3'b110, 4'b1011, 1'b0);
        directed("shl_2",     4'b0110, 4'b0010, 3'b111, 4'b1000, 1'b1);
        directed("and",       4'b1100, 4'b0110, 3'b010, 4'b0100, 1'b0);
        directed("xor",       4'b1100, 4'b0110, 3'b011, 4'b1010, 1'b0);
        directed("or",        4'b1100, 4'b0110, 3'b100, 4'b1110, 1'b0);
        directed("not",       4'b1010, 4'b0011, 3'b101, 4'b0101, 1'b0);
        directed("add_nc",    4'b0011, 4'b0100, 3'b000, 4'b0111, 1'b0);

        // Randomized back-to-back traffic; a single-cycle reset mid-stream
        // plus occasional random ones. The model compare checks every edge.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a     = W'($urandom_range(0, 15));
            b     = W'($urandom_range(0, 15));
            op    = 3'($urandom_range(0, 7));
            rst_n = (i == 200) || ($urandom_range(0, 39) == 0);
            if (i == 200) begin
                @(posedge clk);
                #2;
                check_lit("mid_reset", 4'b0000, 1'b0, a, b, op, 1'b1);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_alu_synth_wrapper
`default_nettype wire
